// File: rtl/div_unit_pkg.sv
// div_unit_pkg: state codes and control constants shared by the divider
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic SIGNED_DIV           = 1'b1;
  localparam logic UNSIGNED_DIV         = 1'b0;

endpackage

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring DIV/DIVU, one quotient bit per clock, {rem, quot} out
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  div_state_e         r_state;
  div_state_e         w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_rq;
  logic [WIDTH-1:0]   r_div;
  logic               r_qneg;
  logic               r_rneg;
  logic               w_go;
  logic               w_signed;
  logic               w_last;
  logic               w_ready;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH:0]     w_sub;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_result;

  assign w_go     = (start_i == DIV_START) && !annul_i;
  assign w_signed = (signed_div_i == SIGNED_DIV) && (signed_div_i != UNSIGNED_DIV);
  assign w_abs1   = (w_signed && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2   = (w_signed && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  // the shifted partial remainder can reach WIDTH+1 bits, so the trial subtract is one bit wider
  assign w_sub    = r_rq[2*WIDTH-1:WIDTH-1] - {1'b0, r_div};
  assign w_step   = w_sub[WIDTH] ? {r_rq[2*WIDTH-2:0], 1'b0}
                                 : {w_sub[WIDTH-1:0], r_rq[WIDTH-2:0], 1'b1};
  assign w_last   = r_cnt == CNT_W'(WIDTH - 1);
  assign w_q      = r_qneg ? -r_rq[WIDTH-1:0] : r_rq[WIDTH-1:0];
  assign w_r      = r_rneg ? -r_rq[2*WIDTH-1:WIDTH] : r_rq[2*WIDTH-1:WIDTH];

  // next state and the values the registered outputs take on the next edge
  always_comb begin
    w_next   = r_state;
    w_ready  = DIV_RESULT_NOT_READY;
    w_result = '0;
    case (r_state)
      DIV_FREE: begin
        if (w_go) begin
          if (opdata2_i == '0) w_next = DIV_BY_ZERO;
          else w_next = DIV_ON;
        end
      end
      DIV_BY_ZERO: w_next = DIV_END;
      DIV_ON: begin
        if (annul_i) w_next = DIV_FREE;
        else if (w_last) w_next = DIV_END;
      end
      DIV_END: begin
        if (annul_i || start_i == DIV_STOP) w_next = DIV_FREE;
        else begin
          w_ready  = DIV_RESULT_READY;
          w_result = {w_r, w_q};
        end
      end
      default: w_next = DIV_FREE;
    endcase
  end

  // state register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= DIV_FREE;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      r_state  <= w_next;
      result_o <= w_result;
      ready_o  <= w_ready;
    end
  end

  // operand capture on start, then one restoring step per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_rq   <= '0;
      r_div  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (r_state == DIV_FREE && w_go) begin
      r_cnt  <= '0;
      r_rq   <= {{WIDTH{1'b0}}, w_abs1};
      r_div  <= w_abs2;
      r_qneg <= w_signed && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
      r_rneg <= w_signed && opdata1_i[WIDTH-1];
    end else if (r_state == DIV_BY_ZERO) begin
      r_rq <= '0;
    end else if (r_state == DIV_ON && !annul_i) begin
      r_rq  <= w_step;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an arithmetic model
module tb_div_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  int             n_cmp = 0;
  int             n_fail = 0;

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return '0;
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
  endtask

  task automatic wait_result(input string tag, input logic [63:0] exp, input int exp_lat);
    int lat = -1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      signed_div_i = 1'($urandom_range(0, 1));
    end while (!ready_o && lat < 40);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result_o, exp);
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    start_op(sgn, a, b);
    wait_result(tag, exp, b == 0 ? 2 : 33);
    @(posedge clk);
    #1;
    check({tag, " hold ready"}, 64'(ready_o), 64'd1);
    check({tag, " hold result"}, result_o, exp);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " drop ready"}, 64'(ready_o), 64'd0);
    check({tag, " drop result"}, result_o, 64'd0);
  endtask

  initial begin
    logic          seen;
    logic          sgn;
    logic [31:0]   a, b;
    logic [31:0]   specials [4];
    specials = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF};

    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD);
    run_div("div 7/-2", 1'b1, 32'h7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD);
    run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 64'd0);
    run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
    run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'h1, 64'h00000000_FFFFFFFF);
    run_div("div min/3", 1'b1, 32'h8000_0000, 32'd3, 64'hFFFFFFFE_D5555556);

    start_op(1'b0, 32'd1000, 32'd3);
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul on ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= ready_o;
    end
    check("annul never ready", 64'(seen), 64'd0);
    run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    start_op(1'b0, 32'd100, 32'd7);
    wait_result("annul end", 64'h00000002_0000000E, 33);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul end ready", 64'(ready_o), 64'd0);
    check("annul end result", result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;

    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b1;
    opdata1_i = 32'd5;
    opdata2_i = 32'd0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen |= ready_o;
    end
    check("annul+start no start", 64'(seen), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk);

    start_op(1'b1, 32'd12345, 32'd17);
    repeat (21) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst mid ready", 64'(ready_o), 64'd0);
    check("rst mid result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;

    start_op(1'b0, 32'd100, 32'd7);
    wait_result("rst end", 64'h00000002_0000000E, 33);
    #2;
    rst = 1'b0;
    #1;
    check("rst end ready", 64'(ready_o), 64'd0);
    check("rst end result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      seen |= ready_o | (|result_o);
    end
    check("after rst idle", 64'(seen), 64'd0);
    run_div("after rst 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: a = specials[$urandom_range(0, 3)];
        3: b = specials[$urandom_range(0, 3)];
        4: b = b >> $urandom_range(8, 28);
        default: ;
      endcase
      run_div($sformatf("rand%0d", i), sgn, a, b, model(sgn, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
